spi_mem_cache: RTL and testbench

SPI_MEM_CACHE -- requirements
Module: spi_mem_cache

---
 rtl/spi_mem_cache.sv | 117 +++++++++++
 tb/tb_spi_mem_cache.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_cache.sv
// Direct-mapped, one-byte-per-line read cache in front of an SPI memory controller.
// Write-through with no write-allocate; every output is registered.
module spi_mem_cache #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    input  logic        cache_flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 16 - IDX_W;

    typedef enum logic [1:0] {IDLE, MEM_ISSUE, MEM_WAIT, RESP} state_t;

    state_t state, state_next;

    logic [LINES-1:0] valid;
    logic [7:0]       line_data [LINES];
    logic [TAG_W-1:0] line_tag  [LINES];
    logic             write_hit;

    logic [IDX_W-1:0] req_idx, mem_idx;
    logic [TAG_W-1:0] req_tag, mem_tag;
    logic             lookup_hit, accept, read_hit, fill_done;

    assign req_idx = cpu_addr[IDX_W-1:0];
    assign req_tag = cpu_addr[15:IDX_W];
    assign mem_idx = mem_addr[IDX_W-1:0];
    assign mem_tag = mem_addr[15:IDX_W];

    // A flush arriving with the request wins, so the lookup sees an empty cache.
    assign lookup_hit = valid[req_idx] && (line_tag[req_idx] == req_tag) && !cache_flush;
    assign accept     = (state == IDLE) && cpu_req;
    assign read_hit   = accept && !cpu_we && lookup_hit;
    assign fill_done  = (state == MEM_WAIT) && mem_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (cpu_req) state_next = (!cpu_we && lookup_hit) ? RESP : MEM_ISSUE;
            MEM_ISSUE: state_next = MEM_WAIT;
            MEM_WAIT:  if (mem_ready) state_next = RESP;
            RESP:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // The mem_* registers double as the latched request, so they stay stable until the reply.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_ready <= 1'b0;
            cpu_rdata <= 8'h00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 8'h00;
            write_hit <= 1'b0;
            hit_cnt   <= 16'h0000;
            miss_cnt  <= 16'h0000;
        end else begin
            cpu_ready <= 1'b0;
            mem_req   <= 1'b0;
            if (read_hit) begin
                cpu_ready <= 1'b1;
                cpu_rdata <= line_data[req_idx];
                if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end else if (accept) begin
                mem_req   <= 1'b1;
                mem_we    <= cpu_we;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
                write_hit <= lookup_hit;
                if (!cpu_we && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
            if (fill_done) begin
                cpu_ready <= 1'b1;
                if (!mem_we) cpu_rdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                    valid <= '0;
        else if (cache_flush)            valid <= '0;
        else if (fill_done && !mem_we)   valid[mem_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            if (!mem_we) begin
                line_data[mem_idx] <= mem_rdata;
                line_tag[mem_idx]  <= mem_tag;
            end else if (write_hit) begin
                line_data[mem_idx] <= mem_wdata;
            end
        end
    end
endmodule

// File: tb/tb_spi_mem_cache.sv
// Directed bench for spi_mem_cache: a vector table of CPU transactions against a
// behavioural SPI memory, plus hand-written flush and reset sequences.
module tb_spi_mem_cache;
    logic        clk, reset_n, cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ready, cache_flush, flush_main, flush_model;
    logic        mem_req, mem_we, mem_ready;
    logic [15:0] mem_addr, hit_cnt, miss_cnt;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0]  mem_store [0:65535];
    int          mem_lat;
    bit          flush_on_ready;
    int          req_count;
    logic [15:0] rec_addr, ready_addr;
    logic        rec_we;
    logic [7:0]  rec_wdata;

    int checks, failures;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          lat;
        bit          exp_mem;
        logic [7:0]  exp_rdata;
        bit          chk_rdata;
        logic [15:0] exp_hits;
        logic [15:0] exp_misses;
    } vec_t;

    vec_t vecs [10];

    assign cache_flush = flush_main | flush_model;

    spi_mem_cache #(.LINES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cache_flush(cache_flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: answers each request mem_lat cycles later and aborts on reset.
    initial begin
        bit live;
        int waited;
        mem_ready   = 1'b0;
        mem_rdata   = 8'h00;
        flush_model = 1'b0;
        req_count   = 0;
        forever begin
            @(negedge clk);
            if (reset_n && mem_req) begin
                req_count++;
                rec_addr  = mem_addr;
                rec_we    = mem_we;
                rec_wdata = mem_wdata;
                if (mem_we) mem_store[mem_addr] = mem_wdata;
                live   = 1'b1;
                waited = 0;
                while (live && waited < mem_lat) begin
                    @(negedge clk);
                    waited++;
                    if (!reset_n)     live = 1'b0;
                    else if (mem_req) req_count++;
                end
                if (live) begin
                    mem_ready   = 1'b1;
                    mem_rdata   = rec_we ? 8'h00 : mem_store[rec_addr];
                    flush_model = flush_on_ready;
                    ready_addr  = mem_addr;
                    @(negedge clk);
                    mem_ready   = 1'b0;
                    flush_model = 1'b0;
                    mem_rdata   = 8'h00;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Issues one CPU request and waits (bounded) for the completion pulse.
    task automatic apply_stimulus(input bit we, input logic [15:0] addr, input logic [7:0] wdata,
                                  input bit flush, output logic [7:0] rdata,
                                  output int cycles, output int reqs);
        int start_reqs;
        @(negedge clk);
        start_reqs = req_count;
        cpu_req    = 1'b1;
        cpu_we     = we;
        cpu_addr   = addr;
        cpu_wdata  = wdata;
        flush_main = flush;
        @(negedge clk);
        cpu_req    = 1'b0;
        flush_main = 1'b0;
        cycles     = 1;
        while (!cpu_ready && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        rdata = cpu_rdata;
        reqs  = req_count - start_reqs;
        @(negedge clk);
        check_output("ready_pulse_width", 32'(cpu_ready), 32'd0);
    endtask

    initial begin
        logic [7:0] rdata;
        int cycles, reqs, seen;
        checks = 0; failures = 0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
        flush_main = 1'b0; flush_on_ready = 1'b0; mem_lat = 3;
        mem_store[16'h0123] = 8'hA5;
        mem_store[16'h0200] = 8'h11;
        mem_store[16'h0003] = 8'h33;
        mem_store[16'h0013] = 8'h44;
        mem_store[16'h0040] = 8'hC4;
        mem_store[16'h0300] = 8'h9E;

        //          we    addr      wdata  lat mem   rdata  chk   hits   misses
        vecs[0] = '{1'b0, 16'h0123, 8'h00, 40, 1'b1, 8'hA5, 1'b1, 16'd0, 16'd1};
        vecs[1] = '{1'b0, 16'h0123, 8'h00, 3,  1'b0, 8'hA5, 1'b1, 16'd1, 16'd1};
        vecs[2] = '{1'b1, 16'h0123, 8'h5A, 3,  1'b1, 8'h00, 1'b0, 16'd1, 16'd1};
        vecs[3] = '{1'b0, 16'h0123, 8'h00, 3,  1'b0, 8'h5A, 1'b1, 16'd2, 16'd1};
        vecs[4] = '{1'b1, 16'h0200, 8'h77, 3,  1'b1, 8'h00, 1'b0, 16'd2, 16'd1};
        vecs[5] = '{1'b0, 16'h0200, 8'h00, 3,  1'b1, 8'h77, 1'b1, 16'd2, 16'd2};
        vecs[6] = '{1'b0, 16'h0003, 8'h00, 2,  1'b1, 8'h33, 1'b1, 16'd2, 16'd3};
        vecs[7] = '{1'b0, 16'h0013, 8'h00, 2,  1'b1, 8'h44, 1'b1, 16'd2, 16'd4};
        vecs[8] = '{1'b0, 16'h0003, 8'h00, 2,  1'b1, 8'h33, 1'b1, 16'd2, 16'd5};
        vecs[9] = '{1'b0, 16'h0003, 8'h00, 3,  1'b0, 8'h33, 1'b1, 16'd3, 16'd5};

        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_cpu_ready", 32'(cpu_ready), 32'd0);
        check_output("reset_cpu_rdata", 32'(cpu_rdata), 32'h00);
        check_output("reset_mem_req",   32'(mem_req),   32'd0);
        check_output("reset_mem_addr",  32'(mem_addr),  32'h0000);
        check_output("reset_hit_cnt",   32'(hit_cnt),   32'd0);
        check_output("reset_miss_cnt",  32'(miss_cnt),  32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            mem_lat = vecs[i].lat;
            apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, rdata, cycles, reqs);
            $display("[TB] vector %0d addr=0x%04h we=%0d", i, vecs[i].addr, vecs[i].we);
            check_output("mem_req_pulses", 32'(reqs), vecs[i].exp_mem ? 32'd1 : 32'd0);
            check_output("latency", 32'(cycles),
                         vecs[i].exp_mem ? 32'(vecs[i].lat + 2) : 32'd1);
            if (vecs[i].exp_mem) begin
                check_output("mem_addr_issue", 32'(rec_addr), 32'(vecs[i].addr));
                check_output("mem_addr_ready", 32'(ready_addr), 32'(vecs[i].addr));
                check_output("mem_we_issue", 32'(rec_we), 32'(vecs[i].we));
                if (vecs[i].we) check_output("mem_wdata_issue", 32'(rec_wdata), 32'(vecs[i].wdata));
            end
            if (vecs[i].chk_rdata) check_output("cpu_rdata", 32'(rdata), 32'(vecs[i].exp_rdata));
            check_output("hit_cnt", 32'(hit_cnt), 32'(vecs[i].exp_hits));
            check_output("miss_cnt", 32'(miss_cnt), 32'(vecs[i].exp_misses));
        end

        // Flush coinciding with the fill: data returned but line left invalid.
        mem_lat = 5;
        flush_on_ready = 1'b1;
        apply_stimulus(1'b0, 16'h0040, 8'h00, 1'b0, rdata, cycles, reqs);
        flush_on_ready = 1'b0;
        check_output("flush_fill_rdata", 32'(rdata), 32'hC4);
        check_output("flush_fill_latency", 32'(cycles), 32'd7);
        check_output("flush_fill_miss_cnt", 32'(miss_cnt), 32'd6);
        apply_stimulus(1'b0, 16'h0040, 8'h00, 1'b0, rdata, cycles, reqs);
        check_output("after_flush_reqs", 32'(reqs), 32'd1);
        check_output("after_flush_rdata", 32'(rdata), 32'hC4);
        check_output("after_flush_miss_cnt", 32'(miss_cnt), 32'd7);

        // Flush together with the request: lookup of a now-cached line must miss.
        apply_stimulus(1'b0, 16'h0040, 8'h00, 1'b1, rdata, cycles, reqs);
        check_output("flush_req_reqs", 32'(reqs), 32'd1);
        check_output("flush_req_miss_cnt", 32'(miss_cnt), 32'd8);
        check_output("flush_req_hit_cnt", 32'(hit_cnt), 32'd3);

        // Reset while waiting on memory.
        mem_lat = 40;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (5) @(negedge clk);
        check_output("pre_reset_mem_addr", 32'(mem_addr), 32'h0300);
        #2 reset_n = 1'b0;
        #1;
        check_output("async_reset_cpu_rdata", 32'(cpu_rdata), 32'h00);
        check_output("async_reset_mem_addr", 32'(mem_addr), 32'h0000);
        check_output("async_reset_mem_req", 32'(mem_req), 32'd0);
        check_output("async_reset_hit_cnt", 32'(hit_cnt), 32'd0);
        check_output("async_reset_miss_cnt", 32'(miss_cnt), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (cpu_ready) seen = 1;
        end
        check_output("no_ready_after_reset", 32'(seen), 32'd0);
        mem_lat = 3;
        apply_stimulus(1'b0, 16'h0040, 8'h00, 1'b0, rdata, cycles, reqs);
        check_output("post_reset_reqs", 32'(reqs), 32'd1);
        check_output("post_reset_rdata", 32'(rdata), 32'hC4);
        check_output("post_reset_miss_cnt", 32'(miss_cnt), 32'd1);
        check_output("post_reset_hit_cnt", 32'(hit_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
